// File: rtl/mko_pkg.sv
// mko_pkg: shared types and constants for the MKO bus scheduler.
// FSM state enum, chip count, idle select/strobe values, chip helpers.
package mko_pkg;

  localparam int MKO_CHIP_NUM = 5;

  localparam logic [4:0] MKO_SEL_IDLE = 5'b11111;
  localparam logic [4:0] MKO_STB_IDLE = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  function automatic logic chip_ok(
    input logic [2:0] c
  );
    return c < 3'(MKO_CHIP_NUM);
  endfunction

  // One-hot chip mask; all zero for an invalid index.
  function automatic logic [4:0] chip_oh(
    input logic [2:0] c
  );
    logic [4:0] r;
    r = '0;
    if (chip_ok(c))
      r = 5'b00001 << c;
    return r;
  endfunction

endpackage

// File: rtl/mko_rr_arb.sv
// mko_rr_arb: 2-way round-robin grant with a last-served pointer.
// Ports: req in, adv/adv_id (DONE pulse + served id), gnt_vld/gnt_id out.
module mko_rr_arb (
  input  logic       CLK_32,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_id,
  output logic       gnt_vld,
  output logic       gnt_id
);

  // Reset to 1 so requester 0 wins the first contention.
  logic last;

  always_ff @(posedge CLK_32) begin
    if (RESET)
      last <= 1'b1;
    else if (adv)
      last <= adv_id;
  end

  always_comb begin
    gnt_vld = |req;
    gnt_id  = req[1];
    if (&req)
      gnt_id = ~last;
  end

endmodule

// File: rtl/mko_bus_sched.sv
// mko_bus_sched: shares the MKO chip bus between host and poller.
// Ports: req_* per requester, ack/err/rd_dat back, MKO_* chip bus.
module mko_bus_sched
  import mko_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK_32,
  input  logic        RESET,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_we_i,
  input  logic [5:0]  req_chip_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  output logic [1:0]  ack_o,
  output logic [1:0]  err_o,
  output logic [15:0] rd_dat_o,
  output logic        busy_o,
  output logic [4:0]  MKO_SELECT_N,
  output logic [4:0]  MKO_STRBD_N,
  output logic        MKO_RDWR_N,
  output logic [15:0] MKO_A,
  output logic [15:0] MKO_D_O,
  output logic        MKO_D_OE,
  input  logic [15:0] MKO_D_I,
  input  logic [4:0]  MKO_READY_N
);

  state_t      st;
  state_t      st_nx;
  logic [15:0] cnt;

  logic        gnt_q;
  logic        we_q;
  logic        err_q;
  logic [2:0]  chip_q;
  logic [15:0] adr_q;
  logic [15:0] dat_q;
  logic [15:0] rd_q;

  logic [4:0]  rdy_s1;
  logic [4:0]  rdy_s2;

  logic        gnt_vld;
  logic        gnt_id;
  logic        adv;
  logic [2:0]  g_chip;
  logic [15:0] g_adr;
  logic [15:0] g_dat;
  logic        g_we;

  logic [4:0]  oh;
  logic        rdy;
  logic        wait_ok;
  logic        wait_to;
  logic        act;

  assign adv = (st == S_DONE);

  mko_rr_arb u_arb (
    .CLK_32  (CLK_32),
    .RESET   (RESET),
    .req     (req_i),
    .adv     (adv),
    .adv_id  (gnt_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign g_chip = gnt_id ? req_chip_i[5:3] : req_chip_i[2:0];
  assign g_adr  = gnt_id ? req_adr_i[31:16] : req_adr_i[15:0];
  assign g_dat  = gnt_id ? req_dat_i[31:16] : req_dat_i[15:0];
  assign g_we   = gnt_id ? req_we_i[1] : req_we_i[0];

  assign oh      = chip_oh(chip_q);
  assign rdy     = |(oh & ~rdy_s2);
  // First two WAIT cycles may still see stale synchronizer data.
  assign wait_ok = (cnt >= 16'd2) && rdy;
  assign wait_to = (cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      st     <= S_IDLE;
      cnt    <= '0;
      gnt_q  <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      chip_q <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      rd_q   <= '0;
      rdy_s1 <= '1;
      rdy_s2 <= '1;
    end else begin
      st     <= st_nx;
      cnt    <= (st_nx != st) ? 16'd0 : cnt + 16'd1;
      rdy_s1 <= MKO_READY_N;
      rdy_s2 <= rdy_s1;
      if (st == S_IDLE && gnt_vld) begin
        gnt_q  <= gnt_id;
        we_q   <= g_we;
        chip_q <= g_chip;
        adr_q  <= g_adr;
        dat_q  <= g_dat;
        err_q  <= ~chip_ok(g_chip);
        rd_q   <= '0;
      end
      if (st == S_WAIT) begin
        if (wait_ok) begin
          if (!we_q)
            rd_q <= MKO_D_I;
        end else if (wait_to) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE: begin
        if (gnt_vld)
          st_nx = chip_ok(g_chip) ? S_SETUP : S_DONE;
      end
      S_SETUP: begin
        if (cnt == 16'(SETUP_CYC - 1))
          st_nx = S_STROBE;
      end
      S_STROBE:
        st_nx = S_WAIT;
      S_WAIT: begin
        if (wait_ok || wait_to)
          st_nx = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == 16'(HOLD_CYC - 1))
          st_nx = S_DONE;
      end
      S_DONE:
        st_nx = S_IDLE;
      default:
        st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    act = (st == S_SETUP) || (st == S_STROBE) ||
          (st == S_WAIT)  || (st == S_HOLD);
    busy_o       = (st != S_IDLE);
    MKO_SELECT_N = act ? ~oh : MKO_SEL_IDLE;
    MKO_STRBD_N  = MKO_STB_IDLE;
    if (st == S_STROBE || st == S_WAIT)
      MKO_STRBD_N = ~oh;
    MKO_RDWR_N = act ? ~we_q : 1'b1;
    MKO_A      = act ? adr_q : 16'd0;
    MKO_D_O    = act ? dat_q : 16'd0;
    MKO_D_OE   = act & we_q;
    ack_o      = '0;
    err_o      = '0;
    rd_dat_o   = '0;
    if (st == S_DONE) begin
      ack_o[gnt_q] = 1'b1;
      err_o[gnt_q] = err_q;
      rd_dat_o     = rd_q;
    end
  end

endmodule

// File: tb/tb_mko_bus_sched.sv
// tb_mko_bus_sched: scoreboard bench for mko_bus_sched.
// Drives requests, queues expected acks, compares on each ack pulse.
module tb_mko_bus_sched;

  logic        CLK_32 = 1'b0;
  logic        RESET;
  logic [1:0]  req_i;
  logic [1:0]  req_we_i;
  logic [5:0]  req_chip_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [15:0] rd_dat_o;
  logic        busy_o;
  logic [4:0]  MKO_SELECT_N;
  logic [4:0]  MKO_STRBD_N;
  logic        MKO_RDWR_N;
  logic [15:0] MKO_A;
  logic [15:0] MKO_D_O;
  logic        MKO_D_OE;
  logic [15:0] MKO_D_I;
  logic [4:0]  MKO_READY_N;

  mko_bus_sched dut (
    .CLK_32       (CLK_32),
    .RESET        (RESET),
    .req_i        (req_i),
    .req_we_i     (req_we_i),
    .req_chip_i   (req_chip_i),
    .req_adr_i    (req_adr_i),
    .req_dat_i    (req_dat_i),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rd_dat_o     (rd_dat_o),
    .busy_o       (busy_o),
    .MKO_SELECT_N (MKO_SELECT_N),
    .MKO_STRBD_N  (MKO_STRBD_N),
    .MKO_RDWR_N   (MKO_RDWR_N),
    .MKO_A        (MKO_A),
    .MKO_D_O      (MKO_D_O),
    .MKO_D_OE     (MKO_D_OE),
    .MKO_D_I      (MKO_D_I),
    .MKO_READY_N  (MKO_READY_N)
  );

  always #5 CLK_32 = ~CLK_32;

  int cyc = 0;
  always @(posedge CLK_32) cyc <= cyc + 1;

  int oh_bad = 0;
  always @(negedge CLK_32)
    if (!RESET && ($countones(~MKO_SELECT_N) > 1 ||
                   $countones(~MKO_STRBD_N) > 1))
      oh_bad <= oh_bad + 1;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [15:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]  o_ack;
  logic [1:0]  o_err;
  logic [15:0] o_rd;
  int          o_cyc;
  bit          o_to;
  int          sel_cnt;
  int          stb_cnt;
  int          wr_bad;
  int          idle_cnt;
  logic [4:0]  sel_seen;

  task automatic start(input int r, input logic we,
                       input logic [2:0] chip,
                       input logic [15:0] adr, input logic [15:0] dat,
                       output int t0);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_32);
      if (!busy_o) break;
    end
    req_we_i[r]             = we;
    req_chip_i[r*3 +: 3]    = chip;
    req_adr_i[r*16 +: 16]   = adr;
    req_dat_i[r*16 +: 16]   = dat;
    req_i[r]                = 1'b1;
    t0                      = cyc;
  endtask

  task automatic wait_ack(input int bound);
    o_to     = 1'b1;
    sel_cnt  = 0;
    stb_cnt  = 0;
    wr_bad   = 0;
    idle_cnt = 0;
    sel_seen = 5'h1f;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK_32);
      if (!busy_o) idle_cnt++;
      if (MKO_SELECT_N != 5'h1f) begin
        sel_cnt++;
        sel_seen = MKO_SELECT_N;
        if (MKO_RDWR_N !== 1'b0 || MKO_D_OE !== 1'b1 ||
            MKO_D_O !== 16'h1234)
          wr_bad++;
      end
      if (MKO_STRBD_N != 5'h1f) stb_cnt++;
      if (ack_o != 2'b00) begin
        o_ack = ack_o;
        o_err = err_o;
        o_rd  = rd_dat_o;
        o_cyc = cyc;
        o_to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK_32);
    @(negedge CLK_32);
    n_chk++;
    if ({MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N} !== 11'h7ff) begin
      n_fail++;
      $display("FAIL reset_sel_strb: got %b want %b",
               {MKO_SELECT_N, MKO_STRBD_N, MKO_RDWR_N}, 11'h7ff);
    end
    n_chk++;
    if ({MKO_A, MKO_D_O, MKO_D_OE} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h want 0",
               {MKO_A, MKO_D_O, MKO_D_OE});
    end
    n_chk++;
    if ({ack_o, err_o, rd_dat_o, busy_o} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h want 0",
               {ack_o, err_o, rd_dat_o, busy_o});
    end
    RESET = 1'b0;
  endtask

  task automatic check_ack(input string nm);
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    if (o_to) begin
      n_fail++;
      $display("FAIL %s_ack: got no ack want %b", nm, e.ack);
    end else if (o_ack !== e.ack || o_err !== e.err ||
                 o_rd !== e.rd) begin
      n_fail++;
      $display("FAIL %s_resp: got ack %b err %b rd %h want %b %b %h",
               nm, o_ack, o_err, o_rd, e.ack, e.err, e.rd);
    end
  endtask

  task automatic test_single_read();
    int t0;
    MKO_D_I     = 16'hBEEF;
    MKO_READY_N = 5'b00000;
    start(0, 1'b0, 3'd2, 16'h0011, 16'h0000, t0);
    sb.push_back('{2'b01, 2'b00, 16'hBEEF, 9});
    wait_ack(40);
    req_i = 2'b00;
    n_chk++;
    if (o_cyc - t0 !== 9) begin
      n_fail++;
      $display("FAIL read_lat: got %0d want 9", o_cyc - t0);
    end
    check_ack("read");
    n_chk++;
    if (sel_seen !== 5'b11011 || stb_cnt !== 4 || sel_cnt !== 8) begin
      n_fail++;
      $display("FAIL read_lines: got sel %b stb %0d selc %0d want 11011 4 8",
               sel_seen, stb_cnt, sel_cnt);
    end
  endtask

  task automatic test_single_write();
    int t0;
    start(1, 1'b1, 3'd4, 16'h0040, 16'h1234, t0);
    sb.push_back('{2'b10, 2'b00, 16'h0000, 9});
    wait_ack(40);
    req_i = 2'b00;
    check_ack("write");
    n_chk++;
    if (wr_bad !== 0 || sel_seen !== 5'b01111 || sel_cnt !== 8) begin
      n_fail++;
      $display("FAIL write_lines: got bad %0d sel %b selc %0d want 0 01111 8",
               wr_bad, sel_seen, sel_cnt);
    end
  endtask

  task automatic test_contention();
    int t0;
    int prev;
    start(0, 1'b0, 3'd2, 16'h0001, 16'h0000, t0);
    req_we_i[1]      = 1'b0;
    req_chip_i[5:3]  = 3'd3;
    req_adr_i[31:16] = 16'h0002;
    req_i[1]         = 1'b1;
    sb.push_back('{2'b01, 2'b00, 16'hBEEF, 9});
    sb.push_back('{2'b10, 2'b00, 16'hBEEF, 10});
    sb.push_back('{2'b01, 2'b00, 16'hBEEF, 10});
    prev = t0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(40);
      if (k == 2) req_i = 2'b00;
      n_chk++;
      if (o_cyc - prev !== sb[0].lat || idle_cnt !== (k == 0 ? 0 : 1)) begin
        n_fail++;
        $display("FAIL cont_gap%0d: got lat %0d idle %0d want %0d %0d",
                 k, o_cyc - prev, idle_cnt, sb[0].lat, (k == 0 ? 0 : 1));
      end
      prev = o_cyc;
      check_ack("cont");
    end
  endtask

  task automatic test_timeout();
    int t0;
    MKO_READY_N = 5'b00010;
    start(0, 1'b0, 3'd1, 16'h0077, 16'h0000, t0);
    sb.push_back('{2'b01, 2'b01, 16'h0000, 261});
    wait_ack(300);
    req_i = 2'b00;
    n_chk++;
    if (o_cyc - t0 !== 261) begin
      n_fail++;
      $display("FAIL tmo_lat: got %0d want 261", o_cyc - t0);
    end
    check_ack("tmo");
    MKO_READY_N = 5'b00000;
  endtask

  task automatic test_invalid_chip();
    int t0;
    start(0, 1'b0, 3'd6, 16'h0033, 16'h0000, t0);
    sb.push_back('{2'b01, 2'b01, 16'h0000, 1});
    wait_ack(20);
    req_i = 2'b00;
    n_chk++;
    if (o_cyc - t0 !== 1 || sel_cnt !== 0 || stb_cnt !== 0) begin
      n_fail++;
      $display("FAIL inv_chip: got lat %0d sel %0d stb %0d want 1 0 0",
               o_cyc - t0, sel_cnt, stb_cnt);
    end
    check_ack("inv");
  endtask

  task automatic test_reset_mid();
    int t0;
    int acks;
    MKO_READY_N = 5'b11111;
    start(1, 1'b0, 3'd0, 16'h0055, 16'h0000, t0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_32);
      if (MKO_STRBD_N != 5'h1f) break;
    end
    repeat (2) @(negedge CLK_32);
    n_chk++;
    if (MKO_STRBD_N !== 5'b11110) begin
      n_fail++;
      $display("FAIL rst_pre: got strb %b want 11110", MKO_STRBD_N);
    end
    RESET = 1'b1;
    @(posedge CLK_32);
    #1;
    n_chk++;
    if (MKO_SELECT_N !== 5'h1f || MKO_STRBD_N !== 5'h1f || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got sel %b strb %b busy %b want 11111 11111 0",
               MKO_SELECT_N, MKO_STRBD_N, busy_o);
    end
    @(negedge CLK_32);
    RESET       = 1'b0;
    req_i       = 2'b00;
    MKO_READY_N = 5'b00000;
    acks        = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_32);
      if (ack_o != 2'b00) acks++;
    end
    n_chk++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rst_noack: got %0d acks want 0", acks);
    end
    start(0, 1'b0, 3'd2, 16'h0001, 16'h0000, t0);
    req_i[1] = 1'b1;
    sb.push_back('{2'b01, 2'b00, 16'hBEEF, 9});
    wait_ack(40);
    req_i = 2'b00;
    check_ack("rst_rr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET       = 1'b1;
    req_i       = '0;
    req_we_i    = '0;
    req_chip_i  = '0;
    req_adr_i   = '0;
    req_dat_i   = '0;
    MKO_D_I     = '0;
    MKO_READY_N = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_invalid_chip();
    test_reset_mid();
    n_chk++;
    if (oh_bad !== 0) begin
      n_fail++;
      $display("FAIL onehot: got %0d bad cycles want 0", oh_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mko_bus_sched.md
# mko_bus_sched

Transaction scheduler that shares the five-channel MKO (1895VA2T) chip bus between two requesters: requester 0 is the host local-bus path and requester 1 is the autonomous status poller. It arbitrates round-robin and sequences each access as setup, strobe, wait-for-ready and hold. It drives the per-chip MKO_SELECT_N and MKO_STRBD_N lines, MKO_RDWR_N, the address bus and the data bus, and returns ack, error and read data to the granted requester.

## Interface
- SETUP_CYC, 2: cycles SELECT_N, RDWR_N, address and data are stable before the strobe.
- HOLD_CYC, 2: cycles SELECT_N, address and data are held after the strobe is released.
- TIMEOUT_CYC, 255: maximum WAIT cycles before an access is aborted with an error.
- CLK_32  in  1  system clock, 32 MHz.
- RESET  in  1  synchronous, active-high reset.
- req_i  in  2  per-requester access request; held high until that requester's ack_o.
- req_we_i  in  2  per-requester access type: 1 = write, 0 = read.
- req_chip_i  in  6  3 bits per requester: target chip 0..4.
- req_adr_i  in  32  16 bits per requester: chip register address.
- req_dat_i  in  32  16 bits per requester: write data.
- ack_o  out  2  one-cycle completion pulse to the granted requester.
- err_o  out  2  error flag, asserted in the same cycle as ack_o.
- rd_dat_o  out  16  read data; valid while ack_o is high.
- busy_o  out  1  high in every state except IDLE.
- MKO_SELECT_N  out  5  per-chip select, active low.
- MKO_STRBD_N  out  5  per-chip strobe, active low.
- MKO_RDWR_N  out  1  0 = write, 1 = read.
- MKO_A  out  16  chip address.
- MKO_D_O  out  16  chip write data.
- MKO_D_OE  out  1  data bus output enable.
- MKO_D_I  in  16  chip read data.
- MKO_READY_N  in  5  per-chip ready, active low, asynchronous.

## Operation
- **Reset values.**
  - MKO_SELECT_N and MKO_STRBD_N = 5'b11111.
  - MKO_RDWR_N = 1.
  - MKO_A, MKO_D_O, MKO_D_OE, ack_o, err_o, rd_dat_o and busy_o = 0.
  - Round-robin pointer favours requester 0.
- **States:** IDLE, SETUP, STROBE, WAIT, HOLD, DONE.
- **IDLE.**
  - If any req_i bit is high, grant one requester. When both are high, grant the one not served last; after reset, requester 0 wins.
  - Latch we, chip, address and data from the granted requester, then go to SETUP.
  - Chip index 5..7: go directly to DONE with the error set. No MKO line toggles.
- **SETUP.**
  - Drive SELECT_N[chip]=0, MKO_RDWR_N=~we, MKO_A, MKO_D_O, and MKO_D_OE=we.
  - Stay SETUP_CYC cycles.
- **STROBE.** Drive STRBD_N[chip]=0 for one cycle, then go to WAIT.
- **WAIT.**
  - Strobe stays asserted.
  - READY_N[chip] passes through a two-flop synchronizer. It is ignored for the first 2 WAIT cycles, which covers stale synchronizer content.
  - From the 3rd WAIT cycle, a low synchronized ready captures MKO_D_I (reads only) and moves to HOLD.
  - If the counter reaches TIMEOUT_CYC first, set the error flag and move to HOLD. rd_dat_o then reads as 0.
- **HOLD.** STRBD_N returns to all ones; select, address and data are held for HOLD_CYC cycles.
- **DONE.**
  - All MKO outputs return to idle values.
  - Pulse ack_o[grant] for one cycle, with err_o[grant] and rd_dat_o valid in the same cycle.
  - Advance the round-robin pointer, then go to IDLE.
- **Request withdrawn mid-access.** The access completes and the ack still pulses.
- **Request held after ack.** The requester competes again at the next IDLE; round-robin then serves the other requester first if it is pending.
- **Select/strobe encoding.** At most one bit of SELECT_N and at most one bit of STRBD_N is ever low.

## Timing
- Every state transition happens on the CLK_32 rising edge.
- **Nominal latency.** With READY_N low throughout, ack_o rises 1+SETUP_CYC+1+3+HOLD_CYC cycles after the first IDLE cycle that samples req_i high. This is 9 with default parameters.
- **Timeout latency.** 1+SETUP_CYC+1+TIMEOUT_CYC+HOLD_CYC cycles.
- **Invalid chip.** ack_o and err_o rise 1 cycle after the first IDLE cycle that samples req_i high.
- **Idle gap.** There is at least one IDLE cycle between consecutive accesses.
- **RESET mid-access.** On the next edge, all outputs go to their reset values and the state goes to IDLE. No ack is issued and the pointer is reset.

## Structure
- **Package mko_pkg:**
  - state enum;
  - MKO_CHIP_NUM=5;
  - a chip-index-valid function;
  - idle constants 5'b11111 for select/strobe.
- **Sub-module mko_rr_arb:** 2-way round-robin grant with a last-served pointer, advanced by a DONE pulse.
- **Synchronizer:** the ready synchronizer is inline.

## Test plan
- **Single read.** Requester 0 reads chip 2, address 16'h0011, READY_N tied low, MKO_D_I=16'hBEEF.
  - SELECT_N=5'b11011 and STRBD_N low for 4 cycles.
  - ack_o=2'b01 at cycle 9 with rd_dat_o=16'hBEEF and err_o=0.
- **Single write.** Requester 1 writes 16'h1234 to chip 4.
  - MKO_RDWR_N=0, MKO_D_OE=1 and MKO_D_O=16'h1234 from SETUP through HOLD.
  - ack_o=2'b10.
- **Contention.** Both requesters held high for 3 accesses: grants go 0, 1, 0, and busy_o drops for exactly one cycle between accesses.
- **Timeout.** READY_N[1] held high: err_o[0]=1 with ack_o, rd_dat_o=0, ack at 1+2+1+255+2 cycles.
- **Invalid chip.** Chip index 6: no SELECT_N or STRBD_N activity; ack_o and err_o high 1 cycle after the grant cycle.
- **Reset mid-access.** RESET pulsed during WAIT: strobe and select return to 5'b11111 on the next edge, no ack is issued, and the next contended grant goes to requester 0.
